// File: rtl/instruction_fetch_queue.sv
// Instruction fetch front end: issues word fetches to instruction memory, tracks up to
// two in-flight requests and buffers returned words in a 2-entry queue for the decoder.
module instruction_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        PC_write,
    output logic        fetch_valid,
    output logic [31:0] instruction_IF,
    output logic [31:0] PC_sumado_IF
);

    logic [31:0] r_fetch_pc;
    logic [31:0] r_ifl_addr [2];
    logic        r_ifl_wptr;
    logic        r_ifl_rptr;
    logic [31:0] r_q_instr [2];
    logic [31:0] r_q_next  [2];
    logic        r_q_wptr;
    logic        r_q_rptr;
    logic [1:0]  r_q_count;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_drop;

    logic [2:0]  w_occupancy;
    logic        w_req;
    logic        w_grant;
    logic        w_rvalid;
    logic        w_keep;
    logic        w_deq;
    logic [31:0] w_ifl_head;

    // A slot is reserved for every in-flight request, so the queue can never overflow.
    assign w_occupancy = {1'b0, r_q_count} + {1'b0, r_outstanding};
    assign w_req       = rst_n && (w_occupancy < 3'd2) && (r_drop == 2'd0) && !redirect;
    assign w_grant     = w_req && imem_gnt;
    assign w_rvalid    = imem_rvalid && (r_outstanding != 2'd0);
    assign w_keep      = w_rvalid && (r_drop == 2'd0) && !redirect;
    assign w_deq       = (r_q_count != 2'd0) && PC_write && !redirect;
    assign w_ifl_head  = r_ifl_addr[r_ifl_rptr];

    assign imem_req       = w_req;
    assign imem_addr      = r_fetch_pc;
    assign fetch_valid    = (r_q_count != 2'd0);
    assign instruction_IF = fetch_valid ? r_q_instr[r_q_rptr] : 32'h0;
    assign PC_sumado_IF   = fetch_valid ? r_q_next[r_q_rptr]  : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_ifl_wptr    <= 1'b0;
            r_ifl_rptr    <= 1'b0;
            r_outstanding <= 2'd0;
            r_drop        <= 2'd0;
        end else begin
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_grant) begin
                r_ifl_wptr <= ~r_ifl_wptr;
            end
            if (w_rvalid) begin
                r_ifl_rptr <= ~r_ifl_rptr;
            end
            r_outstanding <= r_outstanding + {1'b0, w_grant} - {1'b0, w_rvalid};
            // Everything still in flight after this cycle belongs to the old path.
            if (redirect) begin
                r_drop <= r_outstanding - {1'b0, w_rvalid};
            end else if (w_rvalid && (r_drop != 2'd0)) begin
                r_drop <= r_drop - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_wptr  <= 1'b0;
            r_q_rptr  <= 1'b0;
            r_q_count <= 2'd0;
        end else if (redirect) begin
            r_q_wptr  <= 1'b0;
            r_q_rptr  <= 1'b0;
            r_q_count <= 2'd0;
        end else begin
            if (w_keep) begin
                r_q_wptr <= ~r_q_wptr;
            end
            if (w_deq) begin
                r_q_rptr <= ~r_q_rptr;
            end
            r_q_count <= r_q_count + {1'b0, w_keep} - {1'b0, w_deq};
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ifl_addr[gi] <= 32'h0;
                end else if (w_grant && (r_ifl_wptr == 1'(gi))) begin
                    r_ifl_addr[gi] <= r_fetch_pc;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q_instr[gi] <= 32'h0;
                    r_q_next[gi]  <= 32'h0;
                end else if (w_keep && (r_q_wptr == 1'(gi))) begin
                    r_q_instr[gi] <= imem_rdata;
                    r_q_next[gi]  <= w_ifl_head + 32'd4;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomized bench for instruction_fetch_queue: an in-order memory model with random
// grant/latency, plus a queue-based reference model compared against the DUT every cycle.
module tb_instruction_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        PC_write;
    logic        fetch_valid;
    logic [31:0] instruction_IF;
    logic [31:0] PC_sumado_IF;

    instruction_fetch_queue #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .PC_write       (PC_write),
        .fetch_valid    (fetch_valid),
        .instruction_IF (instruction_IF),
        .PC_sumado_IF   (PC_sumado_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int gnt_pct = 100, pw_pct = 100, rv_pct = 100, rd_pct = 0;
    int lat_min = 1, lat_max = 1;
    bit force_redir = 1'b0;
    logic [31:0] force_pc = 32'h0;

    logic [31:0] mem_data  [$];
    int          mem_ready [$];
    logic [31:0] acc       [$];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] nxt;
    } ent_t;
    ent_t        m_q    [$];
    logic [31:0] m_infl [$];
    int          m_drop = 0;
    logic [31:0] m_pc   = 32'h0;
    bit          m_req  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        ent_t h;
        m_req = (m_q.size() + m_infl.size() < 2) && (m_drop == 0) && !redirect;
        check("imem_req", imem_req, m_req);
        check("imem_addr", imem_addr, m_pc);
        check("fetch_valid", fetch_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            h = m_q[0];
            check("instruction_IF", instruction_IF, h.instr);
            check("PC_sumado_IF", PC_sumado_IF, h.nxt);
        end else begin
            check("instruction_IF_empty", instruction_IF, 32'h0);
            check("PC_sumado_IF_empty", PC_sumado_IF, 32'h0);
        end
    endtask

    task automatic model_step();
        bit rv, deq, grant;
        logic [31:0] a;
        rv    = imem_rvalid && (m_infl.size() > 0);
        deq   = !redirect && (m_q.size() > 0) && PC_write;
        grant = m_req && imem_gnt;
        if (deq) void'(m_q.pop_front());
        if (rv) begin
            a = m_infl.pop_front();
            if (m_drop > 0) m_drop--;
            else if (!redirect) m_q.push_back('{imem_rdata, a + 32'd4});
        end
        if (redirect) begin
            m_q.delete();
            m_pc   = redirect_pc;
            m_drop = m_infl.size();
        end else if (grant) begin
            m_infl.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step();
        bit mem_pop;
        logic [31:0] r;
        @(negedge clk);
        imem_gnt = ($urandom_range(99) < gnt_pct);
        PC_write = ($urandom_range(99) < pw_pct);
        r = $urandom();
        redirect    = force_redir || ($urandom_range(99) < rd_pct);
        redirect_pc = force_redir ? force_pc :
                      (($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : (r & 32'hFFFF_FFFC));
        force_redir = 1'b0;
        mem_pop = (mem_data.size() > 0) && (mem_ready[0] <= cyc) && ($urandom_range(99) < rv_pct);
        imem_rvalid = mem_pop;
        imem_rdata  = mem_pop ? mem_data[0] : $urandom();
        #1;
        compare();
        if (fetch_valid && PC_write && !redirect) begin
            $display("txn cycle=%0d instr=%h pc_plus4=%h", cyc, instruction_IF, PC_sumado_IF);
            acc.push_back(PC_sumado_IF);
        end
        if (mem_pop) begin
            void'(mem_data.pop_front());
            void'(mem_ready.pop_front());
        end
        if (imem_req && imem_gnt) begin
            mem_data.push_back(mem_word(imem_addr));
            mem_ready.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        end
        model_step();
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; PC_write = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 32'h0);
        check("rst_fetch_valid", fetch_valid, 32'h0);
        check("rst_instruction_IF", instruction_IF, 32'h0);
        check("rst_PC_sumado_IF", PC_sumado_IF, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        m_q.delete(); m_infl.delete(); m_drop = 0; m_pc = 32'h0;
        mem_data.delete(); mem_ready.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Stale response in the first cycle after release must be ignored.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
    endtask

    task automatic run_until_acc(input int n, input int budget, input string name);
        int k = 0;
        while (acc.size() < n && k < budget) begin
            step();
            k++;
        end
        check(name, acc.size() >= n, 32'h1);
    endtask

    task automatic check_acc(input string name, input int idx, input logic [31:0] exp);
        if (acc.size() > idx) check(name, acc[idx], exp);
    endtask

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; PC_write = 1'b0;

        // Streaming from reset with a 1-cycle memory.
        apply_reset();
        gnt_pct = 100; rv_pct = 100; pw_pct = 100; lat_min = 1; lat_max = 1;
        acc.delete();
        run_until_acc(3, 30, "stream_timeout");
        check_acc("stream_0", 0, 32'h4);
        check_acc("stream_1", 1, 32'h8);
        check_acc("stream_2", 2, 32'hC);

        // Consumer stall fills the queue, then drains in order.
        apply_reset();
        pw_pct = 0;
        repeat (5) step();
        check("stall_req", imem_req, 32'h0);
        check("stall_valid", fetch_valid, 32'h1);
        check("stall_head_pc4", PC_sumado_IF, 32'h4);
        check("stall_head_instr", instruction_IF, mem_word(32'h0));
        pw_pct = 100;
        acc.delete();
        run_until_acc(3, 30, "drain_timeout");
        check_acc("drain_0", 0, 32'h4);
        check_acc("drain_1", 1, 32'h8);
        check_acc("drain_2", 2, 32'hC);

        // Grant withheld: request and address must hold.
        apply_reset();
        gnt_pct = 0; force_redir = 1'b1; force_pc = 32'h8;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("gnt0_req", imem_req, 32'h1);
            check("gnt0_addr", imem_addr, 32'h8);
        end
        gnt_pct = 100;
        acc.delete();
        run_until_acc(1, 30, "gnt0_timeout");
        check_acc("gnt0_first", 0, 32'hC);

        // Redirect with two responses outstanding: both must be dropped.
        apply_reset();
        lat_min = 4; lat_max = 4; pw_pct = 0;
        step();
        step();
        force_redir = 1'b1; force_pc = 32'h40;
        step();
        pw_pct = 100;
        acc.delete();
        run_until_acc(1, 30, "redir_timeout");
        check_acc("redir_first", 0, 32'h44);

        // Address wrap at the top of the address space.
        lat_min = 1; lat_max = 3; gnt_pct = 70; rv_pct = 80;
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
        step();
        acc.delete();
        run_until_acc(2, 80, "wrap_timeout");
        check_acc("wrap_0", 0, 32'h0);
        check_acc("wrap_1", 1, 32'h4);

        // Random traffic with occasional redirects and one mid-stream reset.
        gnt_pct = 60; pw_pct = 60; rv_pct = 70; rd_pct = 4; lat_min = 1; lat_max = 3;
        repeat (700) step();
        begin
            int k = 0;
            while (m_infl.size() != 2 && k < 300) begin
                step();
                k++;
            end
            check("two_outstanding_reached", m_infl.size(), 32'h2);
        end
        apply_reset();
        rd_pct = 0;
        step();
        check("restart_addr", imem_addr, 32'h0);
        rd_pct = 4;
        repeat (800) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
